divider_control: RTL and testbench

//  Sequencing FSM for the 8-bit bit-slice repeated-subtraction divider.

---
 rtl/divider_pkg.sv | 43 ++++
 rtl/divider_control_if.sv | 29 ++
 rtl/divider_control.sv | 57 +++++
 tb/tb_divider_control.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types for the repeated-subtraction divider controller: state encoding
// and the Moore output bundle decoded from each state.
package divider_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CLEAR,
        SUB,
        RESULT,
        DONE
    } state_t;

    typedef struct packed {
        logic en_zero;
        logic en_op1;
        logic en_op2;
        logic en_sub;
        logic load_a;
        logic load_b;
        logic load_m;
        logic load_result;
        logic done;
    } moore_t;

    // Outputs that depend on the state alone; LoadA/Increment in SUB are added by the top.
    function automatic moore_t decode_moore(state_t s);
        moore_t o;
        o = '0;
        case (s)
            LOAD_A: begin o.en_op1 = 1'b1; o.load_a = 1'b1; end
            LOAD_B: begin o.en_op2 = 1'b1; o.load_b = 1'b1; end
            CLEAR:  begin o.en_zero = 1'b1; o.load_m = 1'b1; end
            SUB:    o.en_sub = 1'b1;
            RESULT: o.load_result = 1'b1;
            DONE:   o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/divider_control_if.sv
// Requester handshake, datapath status flags and datapath control strobes
// between the divider controller and its surroundings.
interface divider_control_if;
    logic Req;
    logic nBorrow;
    logic Overflow;
    logic EnableZero;
    logic EnableOp1;
    logic EnableOp2;
    logic EnableSub;
    logic Increment;
    logic LoadA;
    logic LoadB;
    logic LoadM;
    logic LoadResult;
    logic Done;

    modport master (
        output Req, nBorrow, Overflow,
        input  EnableZero, EnableOp1, EnableOp2, EnableSub, Increment,
               LoadA, LoadB, LoadM, LoadResult, Done
    );

    modport slave (
        input  Req, nBorrow, Overflow,
        output EnableZero, EnableOp1, EnableOp2, EnableSub, Increment,
               LoadA, LoadB, LoadM, LoadResult, Done
    );
endinterface

// File: rtl/divider_control.sv
// Sequencing FSM for the 8-bit repeated-subtraction divider: loads operands,
// subtracts until borrow or quotient saturation, then hands back the result.
module divider_control
    import divider_pkg::*;
(
    input  logic            Clock,
    input  logic            Reset,
    divider_control_if.slave bus
);

    state_t r_state;
    state_t w_state_next;
    moore_t r_out;
    moore_t w_out_next;
    logic   w_sub_step;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.Req) w_state_next = LOAD_A;
            LOAD_A:  w_state_next = LOAD_B;
            LOAD_B:  w_state_next = CLEAR;
            CLEAR:   w_state_next = SUB;
            // Borrow ends the division first; overflow saturates (divide-by-zero).
            SUB:     if (!bus.nBorrow || bus.Overflow) w_state_next = RESULT;
            RESULT:  w_state_next = DONE;
            DONE:    if (!bus.Req) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        w_out_next = decode_moore(w_state_next);
    end

    // Outputs are registered alongside the state so they are a pure function of it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
        end
    end

    assign w_sub_step = (r_state == SUB) & bus.nBorrow & ~bus.Overflow;

    assign bus.EnableZero = r_out.en_zero;
    assign bus.EnableOp1  = r_out.en_op1;
    assign bus.EnableOp2  = r_out.en_op2;
    assign bus.EnableSub  = r_out.en_sub;
    assign bus.LoadA      = r_out.load_a | w_sub_step;
    assign bus.Increment  = w_sub_step;
    assign bus.LoadB      = r_out.load_b;
    assign bus.LoadM      = r_out.load_m;
    assign bus.LoadResult = r_out.load_result;
    assign bus.Done       = r_out.done;

endmodule

// File: tb/tb_divider_control.sv
// Bench for divider_control: an 8-bit datapath emulation feeds the status flags,
// and every cycle's outputs are checked against a per-division expected trace.
module tb_divider_control;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    divider_control_if bus ();

    divider_control dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // {EnableZero,EnableOp1,EnableOp2,EnableSub,Increment,LoadA,LoadB,LoadM,LoadResult,Done}
    localparam logic [9:0] V_IDLE = 10'b0000_0_0_0_0_0_0;
    localparam logic [9:0] V_LDA  = 10'b0100_0_1_0_0_0_0;
    localparam logic [9:0] V_LDB  = 10'b0010_0_0_1_0_0_0;
    localparam logic [9:0] V_CLR  = 10'b1000_0_0_0_1_0_0;
    localparam logic [9:0] V_SUBI = 10'b0001_1_1_0_0_0_0;
    localparam logic [9:0] V_SUB  = 10'b0001_0_0_0_0_0_0;
    localparam logic [9:0] V_RES  = 10'b0000_0_0_0_0_1_0;
    localparam logic [9:0] V_DONE = 10'b0000_0_0_0_0_0_1;

    int checks = 0;
    int errors = 0;

    logic [9:0] dv;
    assign dv = {bus.EnableZero, bus.EnableOp1, bus.EnableOp2, bus.EnableSub, bus.Increment,
                 bus.LoadA, bus.LoadB, bus.LoadM, bus.LoadResult, bus.Done};

    // Datapath emulation: operands, A/B/M registers, result capture.
    logic [7:0]  opa = 8'd0;
    logic [7:0]  opb = 8'd0;
    logic [7:0]  pa  = 8'd0;
    logic [7:0]  pb  = 8'd0;
    logic [7:0]  pm  = 8'd0;
    logic [15:0] res = 16'd0;
    logic [7:0]  dbus;

    always_comb begin
        dbus = 8'd0;
        if (bus.EnableOp1)      dbus = opa;
        else if (bus.EnableOp2) dbus = opb;
        else if (bus.EnableSub) dbus = pa - pb;
    end

    assign bus.nBorrow  = (pa >= pb);
    assign bus.Overflow = (pm == 8'hFF);

    always @(posedge Clock) begin
        if (bus.LoadA) pa <= dbus;
        if (bus.LoadB) pb <= dbus;
        if (bus.LoadM) pm <= dbus;
        else if (bus.Increment) pm <= pm + 8'd1;
        if (bus.LoadResult) res <= {pm, pa};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected-trace scoreboard, consumed one entry per cycle.
    logic [9:0] exp_q[$];
    int lat_cnt  = 0;
    int lat_meas = -1;
    bit lat_on   = 1'b0;

    initial begin
        logic [9:0] e;
        forever begin
            @(negedge Clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("outputs", {22'd0, dv}, {22'd0, e});
            end
            if (dv[8]) begin
                lat_cnt = 0;
                lat_on  = 1'b1;
            end else if (lat_on) begin
                lat_cnt++;
                if (dv[0]) begin
                    lat_meas = lat_cnt;
                    lat_on   = 1'b0;
                end
            end
        end
    end

    task automatic cyc(input logic [9:0] e);
        exp_q.push_back(e);
        @(negedge Clock);
        #1;
    endtask

    task automatic divide(input int a, input int b, input int hold, input bit early_drop);
        int q;
        int r;
        q = (b == 0) ? 255 : a / b;
        r = a - q * b;
        opa = a[7:0];
        opb = b[7:0];
        lat_meas = -1;
        bus.Req = 1'b1;
        cyc(V_LDA);
        if (early_drop) bus.Req = 1'b0;
        cyc(V_LDB);
        cyc(V_CLR);
        repeat (q) cyc(V_SUBI);
        cyc(V_SUB);
        cyc(V_RES);
        repeat (hold) cyc(V_DONE);
        bus.Req = 1'b0;
        cyc(V_IDLE);
        chk("latency", lat_meas, 5 + q);
        chk("quotient", {24'd0, res[15:8]}, q);
        chk("remainder", {24'd0, res[7:0]}, r);
        $display("div %0d/%0d q=%0d r=%0d latency=%0d", a, b, res[15:8], res[7:0], lat_meas);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        Reset   = 1'b1;
        bus.Req = 1'b1;
        #2;
        chk("reset_out", {22'd0, dv}, 32'd0);
        cyc(V_IDLE);
        cyc(V_IDLE);
        Reset = 1'b0;

        // 7/2: nBorrow 1,1,1 then 0; Done held 3 cycles under Req.
        divide(7, 2, 3, 1'b0);
        chk("lit_q_7_2", {24'd0, res[15:8]}, 3);
        chk("lit_r_7_2", {24'd0, res[7:0]}, 1);
        chk("lit_lat_7_2", lat_meas, 8);

        // Immediate borrow.
        divide(3, 5, 1, 1'b0);
        chk("lit_res_3_5", {16'd0, res}, 32'h0003);
        chk("lit_lat_3_5", lat_meas, 5);

        // Divide by zero saturates.
        divide(100, 0, 1, 1'b0);
        chk("lit_res_100_0", {16'd0, res}, 32'hFF64);

        // Borrow and overflow flagged together on the final SUB.
        divide(255, 1, 2, 1'b0);
        chk("lit_res_255_1", {16'd0, res}, 32'hFF00);

        // Req dropped early: division still completes.
        divide(20, 6, 1, 1'b1);
        chk("lit_res_20_6", {16'd0, res}, 32'h0302);

        // Asynchronous reset in the middle of the SUB loop.
        opa = 8'd200;
        opb = 8'd1;
        bus.Req = 1'b1;
        cyc(V_LDA);
        cyc(V_LDB);
        cyc(V_CLR);
        repeat (3) cyc(V_SUBI);
        Reset = 1'b1;
        #1;
        chk("async_reset_out", {22'd0, dv}, 32'd0);
        cyc(V_IDLE);
        cyc(V_IDLE);
        Reset = 1'b0;
        $display("async reset mid-SUB applied and released");

        divide(9, 3, 1, 1'b0);
        chk("lit_res_9_3", {16'd0, res}, 32'h0300);

        divide(200, 7, 1, 1'b0);
        chk("lit_res_200_7", {16'd0, res}, 32'h1C04);

        repeat (2) cyc(V_IDLE);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
